// File: rtl/pipelined_output_coordinator.sv
// pipelined_output_coordinator: ROWSxCOLS PE array that ripples block context diagonally and retires per-PE results at a fixed latency
// Ports: clk, reset (sync, active-high), stall (freezes all state)
//   in_valid/in_ready handshake with mat_size, pos_row, pos_col, channel, in_tag
//   per-PE out_valid, out_row, out_col, out_channel, out_tag (flat index i*COLS+j)
//   block_done/done_tag from the last PE, inflight block count, busy
module pipelined_output_coordinator #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int NUM_CH = 64,
  parameter int MAX_N = 512,
  parameter int MACS_PER_CYCLE = 4,
  parameter int TAG_BITS = 4,
  localparam int CH_BITS = $clog2(NUM_CH + 1),
  localparam int N_BITS = $clog2(MAX_N + 1),
  localparam int CT_BITS = $clog2((MAX_N + MACS_PER_CYCLE - 1) / MACS_PER_CYCLE + 1),
  localparam int IF_BITS = $clog2(ROWS + COLS + 1),
  localparam int P = ROWS * COLS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_BITS-1:0]             mat_size,
  input  logic [N_BITS-1:0]             pos_row,
  input  logic [N_BITS-1:0]             pos_col,
  input  logic [CH_BITS-1:0]            channel,
  input  logic [TAG_BITS-1:0]           in_tag,
  output logic [P-1:0]                  out_valid,
  output logic [P-1:0][N_BITS-1:0]      out_row,
  output logic [P-1:0][N_BITS-1:0]      out_col,
  output logic [P-1:0][CH_BITS-1:0]     out_channel,
  output logic [P-1:0][TAG_BITS-1:0]    out_tag,
  output logic                          block_done,
  output logic [TAG_BITS-1:0]           done_tag,
  output logic [IF_BITS-1:0]            inflight,
  output logic                          busy
);
  logic [P-1:0] active, start, ld;
  logic [P-1:0][CT_BITS-1:0] cnt, c, src_c;
  logic [P-1:0][N_BITS-1:0] base_row, base_col, src_row, src_col;
  logic [P-1:0][CH_BITS-1:0] ch, src_ch;
  logic [P-1:0][TAG_BITS-1:0] tag, src_tag;
  logic [N_BITS:0] sum;
  logic [CT_BITS-1:0] c_in;
  logic accept, unused_ctx;
  assign sum = {1'b0, mat_size} + (N_BITS+1)'(MACS_PER_CYCLE - 1);
  assign c_in = (mat_size == '0) ? CT_BITS'(1) : CT_BITS'(sum / (N_BITS+1)'(MACS_PER_CYCLE));
  assign in_ready = !stall && (!active[0] || cnt[0] == '0);
  assign accept = in_valid && in_ready;
  // the last PEs of each row/array never feed a neighbour, so parts of these are deliberately unread
  assign unused_ctx = ^{c, start};
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      localparam int K = i * COLS + j;
      if (K == 0) begin : g_head
        assign ld[K] = accept;
        assign src_c[K] = c_in;
        assign src_row[K] = pos_row;
        assign src_col[K] = pos_col;
        assign src_ch[K] = channel;
        assign src_tag[K] = in_tag;
      end else begin : g_fwd
        // column 0 is fed from the PE above, every other PE from its left neighbour
        localparam int S = (j == 0) ? K - COLS : K - 1;
        assign ld[K] = start[S];
        assign src_c[K] = c[S];
        assign src_row[K] = base_row[S];
        assign src_col[K] = base_col[S];
        assign src_ch[K] = ch[S];
        assign src_tag[K] = tag[S];
      end
      assign out_valid[K] = active[K] && cnt[K] == '0 && !stall;
      assign out_row[K] = base_row[K] + N_BITS'(i);
      assign out_col[K] = base_col[K] + N_BITS'(j);
    end
  end
  assign out_channel = ch;
  assign out_tag = tag;
  assign block_done = out_valid[P-1];
  assign done_tag = tag[P-1];
  assign busy = inflight != '0;
  always_ff @(posedge clk)
    if (reset) begin
      active <= '0;
      start <= '0;
      cnt <= '0;
      c <= '0;
      base_row <= '0;
      base_col <= '0;
      ch <= '0;
      tag <= '0;
      inflight <= '0;
    end else if (!stall) begin
      for (int k = 0; k < P; k++)
        if (ld[k]) begin
          active[k] <= 1'b1;
          start[k] <= 1'b1;
          cnt[k] <= src_c[k] - CT_BITS'(1);
          c[k] <= src_c[k];
          base_row[k] <= src_row[k];
          base_col[k] <= src_col[k];
          ch[k] <= src_ch[k];
          tag[k] <= src_tag[k];
        end else begin
          start[k] <= 1'b0;
          if (cnt[k] != '0) cnt[k] <= cnt[k] - CT_BITS'(1);
          else active[k] <= 1'b0;
        end
      inflight <= inflight + IF_BITS'(accept) - IF_BITS'(block_done);
    end
endmodule

// File: tb/tb_pipelined_output_coordinator.sv
// tb_pipelined_output_coordinator: directed scoreboard bench for pipelined_output_coordinator
module tb_pipelined_output_coordinator;
  localparam int R = 4, C = 4, P = R * C, NB = 10, CB = 7, TB = 4, IB = 4;
  typedef struct {
    int due;
    logic [NB-1:0] row, col;
    logic [CB-1:0] ch;
    logic [TB-1:0] tag;
  } exp_t;
  logic clk = 0, reset = 1, stall = 0, in_valid = 0;
  logic in_ready, block_done, busy;
  logic [NB-1:0] mat_size = '0, pos_row = '0, pos_col = '0;
  logic [CB-1:0] channel = '0;
  logic [TB-1:0] in_tag = '0, done_tag;
  logic [P-1:0] out_valid;
  logic [P-1:0][NB-1:0] out_row, out_col;
  logic [P-1:0][CB-1:0] out_channel;
  logic [P-1:0][TB-1:0] out_tag;
  logic [IB-1:0] inflight;
  exp_t q[P][$];
  exp_t e;
  int checks = 0, failures = 0, ucyc = 0, cyc = 0, exp_if = 0, acc_cyc = 0, done_cyc = 0, cm;
  logic mon_en = 0, acc_flag = 0, model_ready, ev, dn, acc;
  pipelined_output_coordinator dut (
    .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid), .in_ready(in_ready),
    .mat_size(mat_size), .pos_row(pos_row), .pos_col(pos_col), .channel(channel), .in_tag(in_tag),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_channel(out_channel),
    .out_tag(out_tag), .block_done(block_done), .done_tag(done_tag), .inflight(inflight), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, x);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    cyc++;
    model_ready = !stall && !(q[0].size() > 0 && q[0][0].due > ucyc);
    chk("in_ready", in_ready, model_ready);
    chk("inflight", inflight, exp_if);
    chk("busy", busy, exp_if != 0);
    dn = 0;
    for (int k = 0; k < P; k++) begin
      ev = !stall && q[k].size() > 0 && q[k][0].due == ucyc;
      chk($sformatf("valid%0d", k), out_valid[k], ev);
      if (ev) begin
        e = q[k].pop_front();
        chk($sformatf("row%0d", k), out_row[k], e.row);
        chk($sformatf("col%0d", k), out_col[k], e.col);
        chk($sformatf("ch%0d", k), out_channel[k], e.ch);
        chk($sformatf("tag%0d", k), out_tag[k], e.tag);
        if (k == P - 1) begin
          dn = 1;
          done_cyc = cyc;
          chk("done_tag", done_tag, e.tag);
        end
      end
    end
    chk("block_done", block_done, dn);
    acc = in_valid && model_ready && !reset;
    acc_flag = acc;
    if (acc) begin
      acc_cyc = cyc;
      cm = (mat_size == 0) ? 1 : (int'(mat_size) + 3) / 4;
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) begin
          e.due = ucyc + i + j + cm;
          e.row = NB'(int'(pos_row) + i);
          e.col = NB'(int'(pos_col) + j);
          e.ch = channel;
          e.tag = in_tag;
          q[i * C + j].push_back(e);
        end
    end
    if (reset) begin
      for (int k = 0; k < P; k++) q[k].delete();
      exp_if = 0;
    end else exp_if = exp_if + int'(acc) - int'(dn);
    if (!stall) ucyc++;
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic offer(input int m, input int r, input int c, input int h, input int t);
    logic got;
    got = 0;
    in_valid = 1;
    mat_size = NB'(m);
    pos_row = NB'(r);
    pos_col = NB'(c);
    channel = CB'(h);
    in_tag = TB'(t);
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk);
      got = acc_flag;
    end
    #1;
    in_valid = 0;
    chk("accept_timeout", got, 1);
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 300 && exp_if != 0; n++) idle(1);
    chk("idle_timeout", exp_if, 0);
    idle(2);
  endtask
  initial begin
    int a1;
    idle(2);
    reset = 0;
    mon_en = 1;
    @(negedge clk);
    for (int k = 0; k < P; k++) begin
      chk("rst_row", out_row[k], k / C);
      chk("rst_col", out_col[k], k % C);
    end
    idle(1);
    offer(9, 10, 20, 5, 3);
    wait_idle();
    chk("lat_single", done_cyc - acc_cyc, 9);
    offer(4, 0, 0, 1, 1);
    offer(4, 4, 4, 2, 2);
    chk("peak_inflight", inflight, 2);
    wait_idle();
    offer(12, 7, 9, 3, 4);
    a1 = acc_cyc;
    offer(12, 8, 1, 4, 5);
    chk("bp_accept_cycle", acc_cyc - a1, 3);
    wait_idle();
    offer(9, 10, 20, 5, 3);
    idle(1);
    stall = 1;
    idle(2);
    stall = 0;
    wait_idle();
    chk("lat_stall", done_cyc - acc_cyc, 11);
    offer(0, 1, 2, 6, 8);
    wait_idle();
    chk("lat_zero", done_cyc - acc_cyc, 7);
    offer(5, 511, 0, 63, 9);
    wait_idle();
    offer(2, 1022, 1023, 0, 15);
    wait_idle();
    offer(1, 3, 3, 7, 6);
    idle(6);
    offer(1, 5, 5, 8, 7);
    chk("same_cycle", done_cyc, acc_cyc);
    chk("inflight_same", inflight, 1);
    wait_idle();
    offer(9, 10, 20, 5, 3);
    idle(3);
    reset = 1;
    idle(1);
    reset = 0;
    @(negedge clk);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_inflight", inflight, 0);
    idle(15);
    offer(4, 2, 2, 9, 10);
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
